// File: rtl/mult_acc_pkg.sv
// Shared types and helpers for the multiplier product accumulator.
// Groups of COUNT 16-bit products are summed into a saturating accumulator.
package mult_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

    // Minimum accumulator width that can never clamp for a given group length.
    function automatic int acc_min_w(input int count);
        return 16 + $clog2(count);
    endfunction

endpackage

// File: rtl/mult8u_product_accumulator_sat_add.sv
// Combinational unsigned add of a 16-bit product into a W-bit accumulator.
// On carry out, the result clamps to all ones and ovf is raised.
module sat_add_u #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [15:0]  b,
    output logic [W-1:0] y,
    output logic         ovf
);

    logic [W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + (W+1)'(b);
        ovf      = full_sum[W];
        y        = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];
    end

endmodule

// File: rtl/mult8u_product_accumulator.sv
// Sums groups of COUNT consecutive products into a saturating accumulator and
// presents each group total on a registered valid/ready output.
module mult8u_product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    localparam int CNT_W = $clog2(COUNT + 1);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_y;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             transfer;
    logic             start_group;

    sat_add_u #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (product),
        .y   (add_y),
        .ovf (add_ovf)
    );

    assign out_valid = (state_q == ST_DONE);
    assign in_ready  = (state_q != ST_DONE) || out_ready;
    assign sum       = acc_q;
    assign sat       = sat_q;

    assign prod_ext = ACC_W'(product);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    // An accept while DONE implies out_ready, so it always coincides with a transfer.
    assign start_group = accept && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (start_group) begin
            acc_d   = prod_ext;
            cnt_d   = CNT_W'(1);
            sat_d   = 1'b0;
            state_d = (COUNT == 1) ? ST_DONE : ST_ACCUM;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d = add_y;
                        sat_d = sat_q | add_ovf;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(COUNT)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (transfer) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_mult8u_product_accumulator.sv
// Directed and scoreboarded checks of the product accumulator in three
// configurations: COUNT=4/ACC_W=24, COUNT=4/ACC_W=17 and COUNT=1/ACC_W=16.
module tb_mult8u_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: COUNT=4, ACC_W=24
    logic        in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic [15:0] product_a = '0;
    logic        in_ready_a, out_valid_a, sat_a;
    logic [23:0] sum_a;

    // Instance B: COUNT=4, ACC_W=17 (saturating)
    logic        in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic [15:0] product_b = '0;
    logic        in_ready_b, out_valid_b, sat_b;
    logic [16:0] sum_b;

    // Instance C: COUNT=1, ACC_W=16
    logic        in_valid_c = 1'b0, out_ready_c = 1'b0;
    logic [15:0] product_c = '0;
    logic        in_ready_c, out_valid_c, sat_c;
    logic [15:0] sum_c;

    mult8u_product_accumulator #(.COUNT(4), .ACC_W(24)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .product(product_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .sum(sum_a), .sat(sat_a)
    );

    mult8u_product_accumulator #(.COUNT(4), .ACC_W(17)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .product(product_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .sum(sum_b), .sat(sat_b)
    );

    mult8u_product_accumulator #(.COUNT(1), .ACC_W(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .product(product_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .sum(sum_c), .sat(sat_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid_a !== 1'b0 || sum_a !== 24'd0 || sat_a !== 1'b0 || in_ready_a !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state: out_valid=%b sum=%0d sat=%b in_ready=%b, want 0 0 0 1",
                     out_valid_a, sum_a, sat_a, in_ready_a);
        end
        rst = 1'b0;
        step();
        $display("reset: out_valid=%b sum=%0d sat=%b in_ready=%b", out_valid_a, sum_a, sat_a, in_ready_a);
    endtask

    task automatic test_single_group();
        int vals[4] = '{100, 200, 300, 400};
        out_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1'b1;
            product_a  = 16'(vals[i]);
            #1;
            n_checks++;
            if (in_ready_a !== 1'b1) begin
                n_errors++;
                $display("FAIL single_in_ready beat %0d: got %b, want 1", i, in_ready_a);
            end
            step();
            if (i < 3) begin
                n_checks++;
                if (out_valid_a !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_early_valid beat %0d: got %b, want 0", i, out_valid_a);
                end
            end
        end
        in_valid_a = 1'b0;
        n_checks++;
        if (out_valid_a !== 1'b1 || sum_a !== 24'd1000 || sat_a !== 1'b0) begin
            n_errors++;
            $display("FAIL single_result: valid=%b sum=%0d sat=%b, want 1 1000 0", out_valid_a, sum_a, sat_a);
        end
        $display("single group: sum=%0d sat=%b", sum_a, sat_a);
        step();
        n_checks++;
        if (out_valid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL single_valid_width: out_valid=%b one cycle after transfer, want 0", out_valid_a);
        end
    endtask

    task automatic test_back_to_back();
        int vals[8] = '{65025, 65025, 65025, 65025, 1, 2, 3, 4};
        out_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid_a = 1'b1;
            product_a  = 16'(vals[i]);
            #1;
            n_checks++;
            if (in_ready_a !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_in_ready beat %0d: got %b, want 1", i, in_ready_a);
            end
            step();
            if (i == 3) begin
                n_checks++;
                if (out_valid_a !== 1'b1 || sum_a !== 24'd260100) begin
                    n_errors++;
                    $display("FAIL b2b_group1: valid=%b sum=%0d, want 1 260100", out_valid_a, sum_a);
                end
                $display("b2b group 1: sum=%0d", sum_a);
            end else if (i == 7) begin
                n_checks++;
                if (out_valid_a !== 1'b1 || sum_a !== 24'd10) begin
                    n_errors++;
                    $display("FAIL b2b_group2: valid=%b sum=%0d, want 1 10", out_valid_a, sum_a);
                end
                $display("b2b group 2: sum=%0d", sum_a);
            end else begin
                n_checks++;
                if (out_valid_a !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_mid_valid beat %0d: got %b, want 0", i, out_valid_a);
                end
            end
        end
        in_valid_a = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        out_ready_b = 1'b1;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) begin
                in_valid_b = 1'b1;
                product_b  = (g == 0) ? 16'hFFFF : 16'd1;
                step();
            end
            in_valid_b = 1'b0;
            n_checks++;
            if (g == 0) begin
                if (out_valid_b !== 1'b1 || sum_b !== 17'd131071 || sat_b !== 1'b1) begin
                    n_errors++;
                    $display("FAIL sat_group: valid=%b sum=%0d sat=%b, want 1 131071 1", out_valid_b, sum_b, sat_b);
                end
            end else begin
                if (out_valid_b !== 1'b1 || sum_b !== 17'd4 || sat_b !== 1'b0) begin
                    n_errors++;
                    $display("FAIL sat_clear_group: valid=%b sum=%0d sat=%b, want 1 4 0", out_valid_b, sum_b, sat_b);
                end
            end
            $display("saturation group %0d: sum=%0d sat=%b", g, sum_b, sat_b);
        end
        step();
    endtask

    task automatic test_backpressure();
        int vals[4] = '{10, 20, 30, 40};
        out_ready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1'b1;
            product_a  = 16'(vals[i]);
            step();
        end
        product_a = 16'd7;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (in_ready_a !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_in_ready cycle %0d: got %b, want 0", c, in_ready_a);
            end
            step();
            n_checks++;
            if (out_valid_a !== 1'b1 || sum_a !== 24'd100) begin
                n_errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b sum=%0d, want 1 100", c, out_valid_a, sum_a);
            end
        end
        out_ready_a = 1'b1;
        #1;
        n_checks++;
        if (in_ready_a !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release_ready: got %b, want 1", in_ready_a);
        end
        step();
        n_checks++;
        if (out_valid_a !== 1'b0 || sum_a !== 24'd7) begin
            n_errors++;
            $display("FAIL bp_new_group_start: valid=%b acc=%0d, want 0 7", out_valid_a, sum_a);
        end
        product_a = 16'd1;
        repeat (3) step();
        in_valid_a = 1'b0;
        n_checks++;
        if (out_valid_a !== 1'b1 || sum_a !== 24'd10) begin
            n_errors++;
            $display("FAIL bp_next_group: valid=%b sum=%0d, want 1 10", out_valid_a, sum_a);
        end
        $display("backpressure: held sum=100, next group sum=%0d", sum_a);
        step();
    endtask

    task automatic test_random();
        int          groups_done = 0;
        int          cycles = 0;
        int          local_errs = 0;
        logic        pend = 1'b0;
        logic [23:0] pend_sum = '0;
        logic [23:0] m_acc = '0;
        int          m_cnt = 0;
        logic        exp_rdy;
        while (groups_done < 1000 && cycles < 60000) begin
            in_valid_a  = ($urandom_range(0, 3) != 0);
            product_a   = 16'($urandom_range(0, 65535));
            out_ready_a = ($urandom_range(0, 1) != 0);
            #1;
            exp_rdy = !pend || out_ready_a;
            n_checks++;
            if (in_ready_a !== exp_rdy || out_valid_a !== pend) begin
                n_errors++;
                local_errs++;
                $display("FAIL rand_handshake cycle %0d: in_ready=%b out_valid=%b, want %b %b",
                         cycles, in_ready_a, out_valid_a, exp_rdy, pend);
            end
            if (pend && out_ready_a) begin
                n_checks++;
                if (sum_a !== pend_sum || sat_a !== 1'b0) begin
                    n_errors++;
                    local_errs++;
                    $display("FAIL rand_sum group %0d: sum=%0d sat=%b, want %0d 0",
                             groups_done, sum_a, sat_a, pend_sum);
                end
                groups_done++;
                pend = 1'b0;
            end
            if (in_valid_a && exp_rdy) begin
                m_acc = m_acc + 24'(product_a);
                m_cnt++;
                if (m_cnt == 4) begin
                    pend_sum = m_acc;
                    pend     = 1'b1;
                    m_acc    = '0;
                    m_cnt    = 0;
                end
            end
            step();
            cycles++;
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        n_checks++;
        if (groups_done < 1000) begin
            n_errors++;
            $display("FAIL rand_timeout: groups=%0d after %0d cycles, want 1000", groups_done, cycles);
        end
        $display("random: %0d groups in %0d cycles, %0d errors", groups_done, cycles, local_errs);
    endtask

    task automatic test_reset_mid_group();
        out_ready_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid_a = 1'b1;
            product_a  = 16'd50;
            step();
        end
        in_valid_a = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || sum_a !== 24'd0) begin
            n_errors++;
            $display("FAIL rst_mid_group: valid=%b ready=%b sum=%0d, want 0 1 0", out_valid_a, in_ready_a, sum_a);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1'b1;
            product_a  = 16'd5;
            step();
        end
        in_valid_a = 1'b0;
        n_checks++;
        if (out_valid_a !== 1'b1 || sum_a !== 24'd20) begin
            n_errors++;
            $display("FAIL rst_next_group: valid=%b sum=%0d, want 1 20", out_valid_a, sum_a);
        end
        $display("reset mid-group: next sum=%0d", sum_a);
        // Hold a completed group, then check reset drops out_valid without a clock edge.
        out_ready_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_async_valid: out_valid=%b, want 0", out_valid_a);
        end
        #1;
        rst = 1'b0;
        out_ready_a = 1'b1;
        step();
    endtask

    task automatic test_count_one();
        int vals[3] = '{9, 65535, 3};
        out_ready_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_c = 1'b1;
            product_c  = 16'(vals[i]);
            #1;
            n_checks++;
            if (in_ready_c !== 1'b1) begin
                n_errors++;
                $display("FAIL c1_in_ready beat %0d: got %b, want 1", i, in_ready_c);
            end
            step();
            n_checks++;
            if (out_valid_c !== 1'b1 || sum_c !== 16'(vals[i]) || sat_c !== 1'b0) begin
                n_errors++;
                $display("FAIL c1_sum beat %0d: valid=%b sum=%0d sat=%b, want 1 %0d 0",
                         i, out_valid_c, sum_c, sat_c, vals[i]);
            end
            $display("count1 beat %0d: sum=%0d", i, sum_c);
        end
        in_valid_c = 1'b0;
        step();
        n_checks++;
        if (out_valid_c !== 1'b0) begin
            n_errors++;
            $display("FAIL c1_drain: out_valid=%b, want 0", out_valid_c);
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_mid_group();
        test_count_one();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult8u_product_accumulator.md
# mult8u_product_accumulator

Downstream consumer of the registered 8x8 unsigned multiplier wrapper. Takes the 16-bit `product` stream under a valid/ready handshake and sums groups of `COUNT` consecutive products into a wider accumulator. It presents each group sum with a saturation flag on a registered valid/ready output port. The block sits between the multiplier wrapper and any dot-product or filter consumer, and turns the multiplier into a fixed-length MAC.

## Interface
- `COUNT`, default 4: products per group, ≥1.
- `ACC_W`, default 24: accumulator width, ≥16. Fewer than 16+clog2(COUNT) bits is legal and relies on saturation.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `product` is valid this cycle.
- `in_ready`  out  1  block accepts `product` this cycle.
- `product`  in  16  unsigned multiplier result.
- `out_valid`  out  1  `sum` and `sat` hold a completed group.
- `out_ready`  in  1  consumer takes the group this cycle.
- `sum`  out  ACC_W  unsigned group sum, saturated.
- `sat`  out  1  at least one addition in this group clamped.

## Operation
- Accept: `in_valid && in_ready`. Transfer: `out_valid && out_ready`.
- States:
  - IDLE: no partial group.
  - ACCUM: 1..COUNT-1 products taken.
  - DONE: `out_valid=1`, result held.
- Transitions:
  - IDLE on accept: acc := zero-extended `product`, cnt := 1, sat_r := 0. Goes to ACCUM, or to DONE if COUNT==1.
  - ACCUM on accept: acc := sat_add(acc, product), cnt++. Goes to DONE when cnt reaches COUNT.
  - DONE on transfer without accept: goes to IDLE.
  - DONE on transfer plus accept in the same cycle: the product starts a new group, with the IDLE-accept action, and the state goes to ACCUM (DONE if COUNT==1).
- The first product of every group loads the accumulator. There is never a stale add.
- `in_ready = (state != DONE) || out_ready`.
  - Purely combinational from state and `out_ready`.
  - No dependence on `in_valid`.
- `sat_add`: the true (ACC_W+1)-bit sum. If bit ACC_W is set, the result is all ones and sat_r := 1. The flag is sticky for the group.
- `sum`/`sat` are driven from registers. They are stable while `out_valid && !out_ready`.
- No accept cycles (bubbles) are allowed anywhere inside a group. Only accepted beats count.
- Reset mid-group: the partial sum is discarded and the state returns to IDLE. No output is produced for that group.

## Timing
- Reset values:
  - `out_valid=0`, `sum=0`, `sat=0`.
  - `in_ready=1`, state IDLE, cnt=0.
- Latency: `out_valid` rises on the clock edge that accepts the COUNT-th product. `sum` is visible the cycle after that product is presented.
- Throughput: one product per cycle sustained when `out_ready` is held high. There is no dead cycle between groups.
- Backpressure: while DONE and `!out_ready`, `in_ready=0` and the accumulator is frozen.
- The multiplier wrapper adds 2 cycles from operands to `product`. This block adds 1 cycle from last product to `sum`.

## Structure
- Shared package `mult_acc_pkg`:
  - State enum (IDLE, ACCUM, DONE).
  - Function `acc_min_w(count)` = 16+clog2(count), for width checks and bench expectations.
- One sub-module, `sat_add_u`: parameterised width, operands a[W-1:0] and b[15:0], outputs `y` and `ovf`. It is combinational.
- The counter is clog2(COUNT+1) bits wide.

## Test plan
- Reset, then COUNT=4, products 100, 200, 300, 400 back-to-back with `out_ready=1`:
  - `out_valid` for exactly 1 cycle, `sum=1000`, `sat=0`.
  - `in_ready` high throughout.
- Two groups streamed continuously, 4×65025 then 1,2,3,4, with `out_ready=1`:
  - `sum=260100` then `sum=10`.
  - No gap cycle, and the second group does not include the first.
- `ACC_W=17`, products 4×65535:
  - `sum=131071`, `sat=1`.
  - The next group of 4×1 gives `sum=4`, `sat=0`.
- Group completes with `out_ready=0` for 5 cycles while `in_valid=1`:
  - `in_ready=0` and `sum` stable for those 5 cycles.
  - On the `out_ready` cycle the pending product is accepted as the first of the next group.
- Random `in_valid` bubbles plus random `out_ready`, 1000 groups:
  - Scoreboard sums match the reference model.
  - No product lost or duplicated.
- `rst` asserted after 2 of 4 products:
  - `out_valid=0` immediately (asynchronously).
  - The next 4 products 5,5,5,5 give `sum=20`.
  - COUNT=1 variant: every product appears as `sum` 1 cycle later.
